// File: rtl/aes_key_pkg.sv
// Shared constants, FSM encoding and S-box helpers
// for the AES-192 key-schedule engine.
package aes_key_pkg;

  localparam int NK     = 6;
  localparam int NWORDS = 52;
  localparam int NRK    = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as x^254 (maps 0 to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
             ^ 8'h63;
  endfunction

endpackage

// File: rtl/current_word_gen_192.sv
// AES-192 key-schedule word generator:
// produces w[i] from w[i-1] and w[i-6].
module current_word_gen_192
  import aes_key_pkg::*;
(
  input  logic [5:0]  i,
  input  logic [31:0] prev_word,
  input  logic [31:0] prev_period_word,
  output logic [31:0] word
);

  logic [31:0] rot;
  logic [31:0] sub;
  logic [7:0]  rcon;
  logic        key_step;

  assign rot = {prev_word[23:0], prev_word[31:24]};

  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]),
                sbox(rot[15:8]),  sbox(rot[7:0])};

  always_comb begin
    rcon = 8'h00;
    unique case (i)
      6'd6:    rcon = 8'h01;
      6'd12:   rcon = 8'h02;
      6'd18:   rcon = 8'h04;
      6'd24:   rcon = 8'h08;
      6'd30:   rcon = 8'h10;
      6'd36:   rcon = 8'h20;
      6'd42:   rcon = 8'h40;
      6'd48:   rcon = 8'h80;
      default: rcon = 8'h00;
    endcase
  end

  assign key_step = (i % 6'd6) == 6'd0;

  assign word = prev_period_word ^
    (key_step ? (sub ^ {rcon, 24'h0}) : prev_word);

endmodule

// File: rtl/key_expand_192_seq.sv
// Sequential AES-192 key expansion: one word per
// advance, packed into 13 round keys on a valid/ready port.
module key_expand_192_seq
  import aes_key_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [191:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_data,
  output logic         done
);

  state_e state_q, state_d;

  logic [5:0]   j_q;
  logic [31:0]  win_q [NK];
  logic [31:0]  acc_q [3];
  logic [1:0]   cnt_q;
  logic         rk_valid_q;
  logic [3:0]   rk_idx_q;
  logic [127:0] rk_data_q;
  logic         done_q;

  logic        adv;
  logic        xfer;
  logic        load;
  logic        emit;
  logic        finish;
  logic        last;
  logic        j_lt_nk;
  logic [31:0] gen_word;
  logic [31:0] word;

  assign adv     = !rk_valid_q | rk_ready;
  assign xfer    = rk_valid_q & rk_ready;
  assign last    = j_q == 6'(NWORDS - 1);
  assign j_lt_nk = j_q < 6'(NK);

  current_word_gen_192 u_gen (
    .i                (j_q),
    .prev_word        (win_q[NK-1]),
    .prev_period_word (win_q[0]),
    .word             (gen_word)
  );

  always_comb begin
    word = gen_word;
    unique case (j_q)
      6'd0:    word = win_q[0];
      6'd1:    word = win_q[1];
      6'd2:    word = win_q[2];
      6'd3:    word = win_q[3];
      6'd4:    word = win_q[4];
      6'd5:    word = win_q[5];
      default: word = gen_word;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (adv && last) state_d = FLUSH;
      FLUSH:   if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    emit   = 1'b0;
    finish = 1'b0;
    unique case (state_q)
      IDLE:    load   = start;
      RUN:     emit   = adv;
      FLUSH:   finish = xfer;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      j_q   <= '0;
      cnt_q <= '0;
      for (int k = 0; k < NK; k++) win_q[k] <= '0;
      for (int k = 0; k < 3; k++) acc_q[k] <= '0;
    end else if (load) begin
      j_q   <= '0;
      cnt_q <= '0;
      for (int k = 0; k < NK; k++)
        win_q[k] <= key_in[191-32*k -: 32];
    end else if (emit) begin
      j_q   <= j_q + 6'd1;
      cnt_q <= cnt_q + 2'd1;
      if (!j_lt_nk) begin
        for (int k = 0; k < NK - 1; k++)
          win_q[k] <= win_q[k+1];
        win_q[NK-1] <= word;
      end
      unique case (cnt_q)
        2'd0:    acc_q[0] <= word;
        2'd1:    acc_q[1] <= word;
        2'd2:    acc_q[2] <= word;
        default: ;
      endcase
    end
  end

  // A new round key may overwrite one leaving in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rk_valid_q <= 1'b0;
      rk_idx_q   <= '0;
      rk_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= finish;
      if (emit && cnt_q == 2'd3) begin
        rk_valid_q <= 1'b1;
        rk_idx_q   <= j_q[5:2];
        rk_data_q  <= {acc_q[0], acc_q[1], acc_q[2], word};
      end else if (xfer) begin
        rk_valid_q <= 1'b0;
      end
    end
  end

  assign busy     = state_q != IDLE;
  assign rk_valid = rk_valid_q;
  assign rk_idx   = rk_idx_q;
  assign rk_data  = rk_data_q;
  assign done     = done_q;

endmodule

// File: tb/tb_key_expand_192_seq.sv
// Directed bench for key_expand_192_seq with an
// independent key-schedule reference.
module tb_key_expand_192_seq;

  localparam logic [191:0] K_FIPS =
    192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [191:0] K_OTHER =
    192'h000102030405060708090a0b0c0d0e0f1011121314151617;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [191:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [31:0]  exp_w    [52];
  logic [127:0] got_data [13];
  logic [3:0]   got_idx  [13];
  int n_got, cycles, stalls, unstable;
  logic timed_out, busy_at_done;

  always #5 clk = ~clk;

  key_expand_192_seq dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_idx   (rk_idx),
    .rk_data  (rk_data),
    .done     (done)
  );

  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] tb_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = tb_xt(x);
    end
    return p;
  endfunction

  // Inverse by exhaustive search, affine in bitwise form.
  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv, s, c;
    inv = 0;
    c = 8'h63;
    for (int y = 1; y < 256; y++)
      if (tb_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int b = 0; b < 8; b++)
      s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8]
           ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
    return s;
  endfunction

  task automatic build_model(input logic [191:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) exp_w[i] = key[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = exp_w[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]),
             tb_sbox(t[15:8]), tb_sbox(t[7:0])};
        t = t ^ {rc, 24'h0};
        rc = tb_xt(rc);
      end
      exp_w[i] = exp_w[i-6] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int r);
    return {exp_w[4*r], exp_w[4*r+1], exp_w[4*r+2], exp_w[4*r+3]};
  endfunction

  // Drives one expansion from a negedge; returns at the negedge
  // where done is seen (or on a 500-cycle timeout).
  task automatic run(
    input logic [191:0] key,
    input int           stall_pct,
    input int           restart_cyc,
    input logic [191:0] key2
  );
    logic         held;
    logic [127:0] hd;
    logic [3:0]   hi;
    logic         done_seen;
    held = 0; hd = 0; hi = 0;
    done_seen = 0;
    n_got = 0; cycles = 0; stalls = 0; unstable = 0;
    timed_out = 0; busy_at_done = 1'b1;
    start = 1'b1;
    key_in = key;
    rk_ready = 1'b1;
    while (!done_seen && !timed_out) begin
      @(negedge clk);
      cycles++;
      start = (cycles == restart_cyc);
      if (cycles == restart_cyc) key_in = key2;
      if (done) begin
        done_seen = 1;
        busy_at_done = busy;
      end
      if (held && (!rk_valid || rk_data !== hd || rk_idx !== hi))
        unstable++;
      held = 0;
      rk_ready = (stall_pct == 0) ? 1'b1
               : ($urandom_range(0, 99) >= stall_pct);
      if (rk_valid) begin
        if (rk_ready) begin
          if (n_got < 13) begin
            got_data[n_got] = rk_data;
            got_idx[n_got] = rk_idx;
          end
          n_got++;
        end else begin
          stalls++;
          held = 1;
          hd = rk_data;
          hi = rk_idx;
        end
      end
      if (cycles >= 500) timed_out = 1;
    end
    rk_ready = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    start = 1'b0;
    key_in = '0;
    rk_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, rk_valid, rk_idx, rk_data, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {busy, rk_valid, rk_idx, rk_data, done});
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_fips;
    build_model(K_FIPS);
    run(K_FIPS, 0, 0, K_FIPS);
    checks++;
    if (timed_out !== 1'b0 || n_got != 13) begin
      errors++;
      $display("FAIL fips_count got %0d keys timeout %b want 13 0",
               n_got, timed_out);
    end
    checks++;
    if (got_data[0] !== 128'h8e73b0f7da0e6452c810f32b809079e5) begin
      errors++;
      $display("FAIL fips_rk0 got %h", got_data[0]);
    end
    checks++;
    if (got_data[1][63:32] !== 32'hfe0c91f7) begin
      errors++;
      $display("FAIL fips_w6 got %h want fe0c91f7", got_data[1][63:32]);
    end
    checks++;
    if (got_data[12] !== 128'he98ba06f448c773c8ecc720401002202) begin
      errors++;
      $display("FAIL fips_rk12 got %h", got_data[12]);
    end
    checks++;
    if (cycles != 54) begin
      errors++;
      $display("FAIL fips_latency got %0d want 54", cycles);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL fips_busy_at_done got %b want 0", busy_at_done);
    end
    for (int r = 0; r < 13; r++) begin
      checks++;
      if (got_data[r] !== exp_rk(r) || got_idx[r] !== 4'(r)) begin
        errors++;
        $display("FAIL fips_rk%0d got %h/%0d want %h/%0d",
                 r, got_data[r], got_idx[r], exp_rk(r), r);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width got %b want 0", done);
    end
  endtask

  task automatic test_backpressure;
    int bad;
    build_model(K_FIPS);
    run(K_FIPS, 50, 0, K_FIPS);
    bad = 0;
    for (int r = 0; r < 13; r++)
      if (got_data[r] !== exp_rk(r) || got_idx[r] !== 4'(r)) bad++;
    checks++;
    if (n_got != 13 || bad != 0) begin
      errors++;
      $display("FAIL bp_keys got %0d keys %0d wrong want 13 0",
               n_got, bad);
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL bp_stable got %0d changes want 0", unstable);
    end
    checks++;
    if (timed_out || cycles != 54 + stalls) begin
      errors++;
      $display("FAIL bp_latency got %0d want %0d", cycles, 54 + stalls);
    end
  endtask

  task automatic test_start_ignored;
    int bad;
    build_model(K_FIPS);
    run(K_FIPS, 0, 10, K_OTHER);
    bad = 0;
    for (int r = 0; r < 13; r++)
      if (got_data[r] !== exp_rk(r)) bad++;
    checks++;
    if (n_got != 13 || bad != 0) begin
      errors++;
      $display("FAIL restart_keys got %0d keys %0d wrong want 13 0",
               n_got, bad);
    end
    checks++;
    if (timed_out || cycles != 54) begin
      errors++;
      $display("FAIL restart_latency got %0d want 54", cycles);
    end
  endtask

  task automatic test_mid_reset;
    int spurious;
    int bad;
    start = 1'b1;
    key_in = K_FIPS;
    rk_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      start = 1'b0;
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({busy, rk_valid, rk_idx, rk_data, done} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %h want 0",
               {busy, rk_valid, rk_idx, rk_data, done});
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    spurious = 0;
    repeat (6) begin
      @(negedge clk);
      if (rk_valid || busy || done) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL midreset_quiet got %0d active cycles want 0",
               spurious);
    end
    build_model(K_FIPS);
    run(K_FIPS, 0, 0, K_FIPS);
    bad = 0;
    for (int r = 0; r < 13; r++)
      if (got_data[r] !== exp_rk(r)) bad++;
    checks++;
    if (n_got != 13 || bad != 0 || cycles != 54) begin
      errors++;
      $display("FAIL midreset_rerun got %0d keys %0d wrong %0d cyc want 13 0 54",
               n_got, bad, cycles);
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    build_model('0);
    run('0, 0, 0, '0);
    checks++;
    if (got_data[0] !== 128'h0) begin
      errors++;
      $display("FAIL zero_rk0 got %h want 0", got_data[0]);
    end
    checks++;
    if (got_data[1][63:32] !== 32'h62636363) begin
      errors++;
      $display("FAIL zero_w6 got %h want 62636363", got_data[1][63:32]);
    end
    bad = 0;
    for (int r = 0; r < 13; r++)
      if (got_data[r] !== exp_rk(r)) bad++;
    checks++;
    if (n_got != 13 || bad != 0) begin
      errors++;
      $display("FAIL zero_keys got %0d keys %0d wrong want 13 0",
               n_got, bad);
    end
    build_model(K_FIPS);
    run(K_FIPS, 0, 0, K_FIPS);
    bad = 0;
    for (int r = 0; r < 13; r++)
      if (got_data[r] !== exp_rk(r)) bad++;
    checks++;
    if (n_got != 13 || bad != 0 || cycles != 54) begin
      errors++;
      $display("FAIL b2b_run got %0d keys %0d wrong %0d cyc want 13 0 54",
               n_got, bad, cycles);
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_backpressure();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_expand_192_seq.md
# key_expand_192_seq

Sequential AES-192 key-schedule engine. Accepts a 192-bit cipher key on a start handshake and iterates the combinational word generator over w[6]..w[51], holding a 6-word sliding window. It packs the 52 words into 13 round keys of 128 bits and streams them to the round-key memory over a valid/ready port. It sits between the host register interface (key/start) and the round-key storage read by the cipher rounds.

## Interface
- No parameters. Fixed localparams: NK = 6, NWORDS = 52, NRK = 13.
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request to expand; accepted only when busy = 0
- key_in  in  192  cipher key; key_in[191:160] = w[0], key_in[31:0] = w[5]; sampled only on the accepting edge
- busy  out  1  high from the edge after start acceptance until the done pulse
- rk_valid  out  1  rk_data/rk_idx hold a round key
- rk_ready  in  1  downstream accepts; transfer occurs when rk_valid & rk_ready at a rising edge
- rk_idx  out  4  round-key index 0..12
- rk_data  out  128  round key; {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in [127:96]
- done  out  1  one-cycle pulse after round key 12 is transferred

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE, start = 1: load window win[0..5] <= key words w[0..5], set j <= 0, packer count <= 0, go to RUN, busy <= 1.
- RUN emits word j on every edge where adv = !rk_valid | rk_ready:
  - j < 6: emit win[j]; window unchanged.
  - j >= 6: emit gen(i = j, prev_word = win[5], prev_period_word = win[0]); shift window so win[k] <= win[k+1] and win[5] <= the new word.
  - j increments (6 bits). After word 51 is emitted, go to FLUSH.
- Packer: a 3-word accumulator plus a 2-bit count. The 4th word forms rk_data, sets rk_valid, and sets rk_idx = j[5:2].
- FLUSH: wait for transfer of rk_idx 12. Then done = 1 for one cycle, busy <= 0, go to IDLE.
- start while busy: ignored; key_in not sampled.
- adv = 0 (output pending, not accepted): j, window, packer and state all hold. rk_valid, rk_idx and rk_data must stay stable until transferred.
- Transfer in the same cycle that a new 4th word arrives: the new round key replaces the old one, and rk_valid stays 1.
- Reset, any state: state = IDLE, busy = 0, rk_valid = 0, rk_idx = 0, rk_data = 0, done = 0, j = 0, window = 0, packer = 0. A partial expansion is discarded and no further transfers occur.

## Timing
- Edge E0 accepts start. With rk_ready held at 1, words w[0..51] are captured on edges E1..E52.
- Round key r: rk_valid is high after edge E(4r+4), for exactly one cycle.
- Round key 12 is transferred at E53. done is high during the cycle after E53, and busy falls at the same edge.
- Latency from start to done, no backpressure: 54 cycles.
- Each rk_ready = 0 cycle while rk_valid = 1 adds exactly one cycle.
- start can be re-accepted in the first IDLE cycle after done.

## Structure
- Shared package aes_key_pkg holds:
  - NK, NWORDS, NRK
  - the state encoding: IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2
- One sub-module: the existing combinational current_word_gen_192, instantiated once with i = j.
- Everything else is in this module: window, counter, packer, output register, FSM.

## Test plan
- FIPS-197 A.2 key 8e73b0f7da0e6452c810f32b809079e5 62f8ead2522c6b7b, rk_ready tied 1:
  - rk_idx 0 = 8e73b0f7da0e6452c810f32b809079e5
  - word w[6] = fe0c91f7
  - rk_idx 12 = e98ba06f448c773c8ecc720401002202
  - done 54 cycles after start
- Same key with rk_ready randomly low ~50%:
  - identical 13 round keys, in index order, each stable while stalled
  - done delayed by exactly the number of stall cycles
- start pulsed again at cycle 10 with a different key_in:
  - ignored; output identical to the first run
- resetn asserted at cycle 20 (mid-expansion):
  - all outputs 0 immediately; no rk_valid until a new start
  - a subsequent run produces correct keys
- All-zero key, rk_ready = 1:
  - rk_idx 0 = 0
  - word w[6] = 62636363
  - back-to-back start immediately after done is accepted
